// File: rtl/eth_tx_fsm.sv
// eth_tx_fsm: egress serializer that pops one packed packet from the port FIFO and emits it as
// dest/src/data/crc beats. Define ETH_TX_ADDR_FILTER_EN to discard packets with an unknown dest.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef PKT_WIDTH
`define PKT_WIDTH (4*`DATA_WIDTH+2)
`endif
`ifndef PORT_A_ADDR
`define PORT_A_ADDR 32'h0000_000A
`endif
`ifndef PORT_B_ADDR
`define PORT_B_ADDR 32'h0000_000B
`endif
`ifndef IP_PORT_A_ADDR
`define IP_PORT_A_ADDR 32'hC0A8_0001
`endif
`ifndef CRC_DATA
`define CRC_DATA 32'hDEAD_BEEF
`endif

module eth_tx_fsm #(
  parameter int IFG       = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  input  logic [`PKT_WIDTH-1:0]  fifo_rd_data,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [`DATA_WIDTH-1:0] outdata,
  output logic                   outsop,
  output logic                   outeop,
  output logic [CNT_WIDTH-1:0]   pkt_sent_cnt,
  output logic [CNT_WIDTH-1:0]   pkt_drop_cnt
);

  localparam int DW    = `DATA_WIDTH;
  localparam int PW    = `PKT_WIDTH;
  localparam int GAP_W = (IFG > 1) ? $clog2(IFG) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = (IFG > 1) ? GAP_W'(IFG - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_LOAD, S_DEST, S_SRC, S_DATA, S_CRC, S_GAP
  } state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        pkt_q, pkt_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [CNT_WIDTH-1:0] sent_q, sent_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;

  logic [DW-1:0] dest_w, data_w, src_w, crc_w;
  logic          addr_ok;
  logic          unused_markers;

  assign dest_w = pkt_q[DW:1];
  assign data_w = pkt_q[2*DW:DW+1];
  assign src_w  = pkt_q[3*DW:2*DW+1];
  assign crc_w  = pkt_q[4*DW:3*DW+1];
  // Stored sop/eop bits are ignored; beat markers come from the state.
  assign unused_markers = pkt_q[0] ^ pkt_q[PW-1];

`ifdef ETH_TX_ADDR_FILTER_EN
  assign addr_ok = (dest_w == `PORT_A_ADDR) || (dest_w == `PORT_B_ADDR);
`else
  assign addr_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      pkt_q   <= '0;
      gap_q   <= '0;
      sent_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      gap_q   <= gap_d;
      sent_q  <= sent_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    gap_d   = gap_q;
    sent_d  = sent_q;
    drop_d  = drop_q;
    case (state_q)
      S_IDLE: if (!fifo_empty) state_d = S_WAIT;
      S_WAIT: begin
        pkt_d   = fifo_rd_data;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (addr_ok) begin
          state_d = S_DEST;
        end else begin
          drop_d  = drop_q + CNT_WIDTH'(1);
          state_d = S_IDLE;
        end
      end
      S_DEST: if (out_ready) state_d = S_SRC;
      S_SRC:  if (out_ready) state_d = S_DATA;
      S_DATA: if (out_ready) state_d = S_CRC;
      S_CRC: begin
        if (out_ready) begin
          sent_d  = sent_q + CNT_WIDTH'(1);
          state_d = (IFG > 0) ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Only fifo_rd_en looks at an input; every beat output decodes registered state.
  always_comb begin
    fifo_rd_en = 1'b0;
    out_valid  = 1'b0;
    outsop     = 1'b0;
    outeop     = 1'b0;
    outdata    = '0;
    case (state_q)
      S_IDLE: fifo_rd_en = !fifo_empty;
      S_DEST: begin
        out_valid = 1'b1;
        outsop    = 1'b1;
        outdata   = dest_w;
      end
      S_SRC: begin
        out_valid = 1'b1;
        outdata   = src_w;
      end
      S_DATA: begin
        out_valid = 1'b1;
        outdata   = data_w;
      end
      S_CRC: begin
        out_valid = 1'b1;
        outeop    = 1'b1;
        outdata   = crc_w;
      end
      default: ;
    endcase
  end

  assign pkt_sent_cnt = sent_q;
  assign pkt_drop_cnt = drop_q;

endmodule
